circle_extents: RTL

- Per-frame extents detector on the camera/mask pixel stream. It is the producer end of the two-point circle interface consumed by the circle renderer.
- Scans a binary object mask in raster order and tracks the leftmost and rightmost mask pixels.
- At end of frame, publishes two points (x_out_1,y_out_1) and (x_out_2,y_out_2) that the renderer reads as a diameter's endpoints, plus valid and found flags.

---
 rtl/circle_extents.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/circle_extents.sv
// Per-frame leftmost/rightmost mask-pixel detector. It reports both extreme points once per frame.
// Defining CIRCLE_EXTENTS_SMOOTH_EN averages each report with the previous found report.
module circle_extents #(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int MIN_PIXELS = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        pixel_valid_in,
  input  logic        mask_in,
  output logic [10:0] x_out_1,
  output logic [9:0]  y_out_1,
  output logic [10:0] x_out_2,
  output logic [9:0]  y_out_2,
  output logic        found_out,
  output logic        valid_out
);

  localparam logic [10:0] H_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [20:0] MIN_CNT = 21'(MIN_PIXELS);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REPORT} state_t;

  state_t      r_state, w_state_nx;
  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        r_pix_valid, r_mask;

  logic [10:0] r_min_x, r_max_x, w_min_x_nx, w_max_x_nx;
  logic [9:0]  r_min_y, r_max_y, w_min_y_nx, w_max_y_nx;
  logic [20:0] r_count, w_count_nx;

  logic [10:0] r_x1, r_x2;
  logic [9:0]  r_y1, r_y2;
  logic        r_found, r_valid;

  logic w_counted, w_sof, w_eof;
  logic w_init, w_fold, w_report, w_found;

  // Stage 0: register the incoming sample; everything downstream works on this copy.
  // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hcount    <= '0;
      r_vcount    <= '0;
      r_pix_valid <= 1'b0;
      r_mask      <= 1'b0;
    end else begin
      r_hcount    <= hcount_in;
      r_vcount    <= vcount_in;
      r_pix_valid <= pixel_valid_in;
      r_mask      <= mask_in;
    end
  end

  assign w_counted = r_pix_valid && (r_hcount <= H_LAST) && (r_vcount <= V_LAST);
  assign w_sof     = w_counted && (r_hcount == '0) && (r_vcount == '0);
  assign w_eof     = w_counted && (r_hcount == H_LAST) && (r_vcount == V_LAST);
  assign w_found   = (r_count >= MIN_CNT);

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_sof) w_state_nx = S_ACCUM;
      S_ACCUM:  if (w_eof) w_state_nx = S_REPORT;
      S_REPORT: w_state_nx = w_sof ? S_ACCUM : S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_init   = 1'b0;
    w_fold   = 1'b0;
    w_report = 1'b0;
    case (r_state)
      S_IDLE:   begin w_init = w_sof; w_fold = w_sof; end
      S_ACCUM:  begin w_init = w_sof; w_fold = w_counted; end
      S_REPORT: begin w_init = w_sof; w_fold = w_sof; w_report = 1'b1; end
      default:  ;
    endcase
  end

  // Strict compares keep the first occurrence in raster order on ties.
  always_comb begin
    w_min_x_nx = w_init ? 11'h7ff : r_min_x;
    w_min_y_nx = w_init ? '0 : r_min_y;
    w_max_x_nx = w_init ? '0 : r_max_x;
    w_max_y_nx = w_init ? '0 : r_max_y;
    w_count_nx = w_init ? '0 : r_count;
    if (w_fold && r_mask) begin
      if (r_hcount < w_min_x_nx) begin
        w_min_x_nx = r_hcount;
        w_min_y_nx = r_vcount;
      end
      if (r_hcount > w_max_x_nx) begin
        w_max_x_nx = r_hcount;
        w_max_y_nx = r_vcount;
      end
      if (w_count_nx != '1) w_count_nx = w_count_nx + 21'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_min_x <= '0;
      r_min_y <= '0;
      r_max_x <= '0;
      r_max_y <= '0;
      r_count <= '0;
    end else begin
      r_min_x <= w_min_x_nx;
      r_min_y <= w_min_y_nx;
      r_max_x <= w_max_x_nx;
      r_max_y <= w_max_y_nx;
      r_count <= w_count_nx;
    end
  end

`ifdef CIRCLE_EXTENTS_SMOOTH_EN
  logic r_hist;

  function automatic logic [10:0] avg11(input logic [10:0] a, input logic [10:0] b);
    return 11'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

  function automatic logic [9:0] avg10(input logic [9:0] a, input logic [9:0] b);
    return 10'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_x1    <= '0;
      r_y1    <= '0;
      r_x2    <= '0;
      r_y2    <= '0;
      r_found <= 1'b0;
      r_valid <= 1'b0;
`ifdef CIRCLE_EXTENTS_SMOOTH_EN
      r_hist  <= 1'b0;
`endif
    end else begin
      r_valid <= w_report;
      if (w_report) begin
        r_found <= w_found;
`ifdef CIRCLE_EXTENTS_SMOOTH_EN
        r_hist  <= w_found;
        if (w_found && r_hist) begin
          r_x1 <= avg11(r_x1, r_min_x);
          r_y1 <= avg10(r_y1, r_min_y);
          r_x2 <= avg11(r_x2, r_max_x);
          r_y2 <= avg10(r_y2, r_max_y);
        end else if (w_found) begin
`else
        if (w_found) begin
`endif
          r_x1 <= r_min_x;
          r_y1 <= r_min_y;
          r_x2 <= r_max_x;
          r_y2 <= r_max_y;
        end
      end
    end
  end

  assign x_out_1   = r_x1;
  assign y_out_1   = r_y1;
  assign x_out_2   = r_x2;
  assign y_out_2   = r_y2;
  assign found_out = r_found;
  assign valid_out = r_valid;

endmodule
